// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, default sizes and datapath select codes for gcd_sched
package gcd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE} gcd_state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_REQ = 4;
  localparam logic SEL_EXT = 1'b1;
  localparam logic SUB_AMB = 1'b0;
  localparam logic SUB_BMA = 1'b1;
endpackage

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: round-robin arbiter searching from ptr, advancing ptr past each winner
module gcd_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = 1;
  logic [IW-1:0] ptr_q, ptr_d, k;
  logic found;
  always_comb begin
    found = 1'b0;
    idx = '0;
    k = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = IW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
    gnt = (en && found) ? ONE << idx : '0;
    ptr_d = (en && found) ? ((idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin sequencer sharing one subtractive GCD datapath between N_REQ clients
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]         resp_gcd,
  output logic [WIDTH:0]           resp_iters,
  output logic [WIDTH-1:0]         dp_data_in,
  output logic                     dp_sel_in,
  output logic                     dp_sel_sub,
  output logic                     dp_ld_a,
  output logic                     dp_ld_b,
  input  logic                     dp_lt,
  input  logic                     dp_gt,
  input  logic                     dp_eq,
  input  logic [WIDTH-1:0]         dp_a
);
  localparam int IW = $clog2(N_REQ);
  gcd_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d, a_win, b_win;
  logic [WIDTH:0] iters_q, iters_d;
  logic [IW-1:0] id_q, id_d, win;
  gcd_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk), .rst_n(rst_n), .en(state_q == IDLE && rst_n), .req(req), .gnt(gnt), .idx(win)
  );
  assign a_win = a_in[win*WIDTH +: WIDTH];
  assign b_win = b_in[win*WIDTH +: WIDTH];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    id_d = id_q;
    gcd_d = gcd_q;
    iters_d = iters_q;
    case (state_q)
      IDLE: if (|gnt) begin
        a_d = a_win;
        b_d = b_win;
        id_d = win;
        iters_d = '0;
        gcd_d = a_win | b_win;
        state_d = (a_win == '0 || b_win == '0) ? DONE : LOAD_A;
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = CMP;
      CMP: begin
        state_d = dp_eq ? DONE : dp_gt ? SUB_A : dp_lt ? SUB_B : CMP;
        gcd_d = dp_eq ? dp_a : gcd_q;
      end
      SUB_A, SUB_B: begin
        state_d = CMP;
        iters_d = &iters_q ? iters_q : iters_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      gcd_q <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      gcd_q <= gcd_d;
      iters_q <= iters_d;
    end
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == DONE;
  assign resp_id = resp_valid ? id_q : '0;
  assign resp_gcd = resp_valid ? gcd_q : '0;
  assign resp_iters = resp_valid ? iters_q : '0;
  assign dp_data_in = state_q == LOAD_A ? a_q : state_q == LOAD_B ? b_q : '0;
  assign dp_sel_in = (state_q == LOAD_A || state_q == LOAD_B) ? SEL_EXT : ~SEL_EXT;
  assign dp_sel_sub = state_q == SUB_B ? SUB_BMA : SUB_AMB;
  assign dp_ld_a = state_q == LOAD_A || state_q == SUB_A;
  assign dp_ld_b = state_q == LOAD_B || state_q == SUB_B;
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: directed checks of gcd_sched against a behavioural GCD datapath
module tb_gcd_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] a_in = '0, b_in = '0;
  logic [3:0] gnt;
  logic busy, resp_valid, dp_sel_in, dp_sel_sub, dp_ld_a, dp_ld_b;
  logic [1:0] resp_id;
  logic [15:0] resp_gcd, dp_data_in;
  logic [16:0] resp_iters;
  logic [15:0] ra = '0, rb = '0;
  logic [63:0] all_outs;
  int total = 0, bad = 0;
  int lat, ld;
  bit seen;
  gcd_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt), .busy(busy),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_gcd(resp_gcd), .resp_iters(resp_iters),
    .dp_data_in(dp_data_in), .dp_sel_in(dp_sel_in), .dp_sel_sub(dp_sel_sub),
    .dp_ld_a(dp_ld_a), .dp_ld_b(dp_ld_b),
    .dp_lt(ra < rb), .dp_gt(ra > rb), .dp_eq(ra == rb), .dp_a(ra)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (dp_ld_a) ra <= dp_sel_in ? dp_data_in : (dp_sel_sub ? rb - ra : ra - rb);
    if (dp_ld_b) rb <= dp_sel_in ? dp_data_in : (dp_sel_sub ? rb - ra : ra - rb);
  end
  assign all_outs = {3'b0, gnt, busy, resp_valid, resp_id, resp_gcd, resp_iters,
                     dp_data_in, dp_sel_in, dp_sel_sub, dp_ld_a, dp_ld_b};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_resp(input int drop_id, output int l, output int n);
    l = -1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0 && drop_id >= 0) req[drop_id] = 1'b0;
      n += int'(dp_ld_a) + int'(dp_ld_b);
      if (resp_valid) begin
        l = i + 1;
        break;
      end
    end
  endtask
  task automatic run(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                     input int g, input int it, input int l_exp, input int ld_exp);
    @(negedge clk);
    a_in[id*16 +: 16] = a;
    b_in[id*16 +: 16] = b;
    req[id] = 1'b1;
    #1;
    chk({tag, "_gnt"}, gnt, 64'(1) << id);
    wait_resp(id, lat, ld);
    chk({tag, "_lat"}, lat, l_exp);
    chk({tag, "_gcd"}, resp_gcd, g);
    chk({tag, "_id"}, resp_id, id);
    chk({tag, "_iters"}, resp_iters, it);
    chk({tag, "_ldcnt"}, ld, ld_exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {resp_valid, busy}, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", all_outs, 0);
    rst_n = 1'b1;
    run("basic", 0, 16'd12, 16'd8, 4, 2, 8, 4);
    run("equal", 2, 16'd7, 16'd7, 7, 0, 4, 2);
    run("long", 3, 16'd5, 16'd1, 1, 4, 12, 6);
    run("zero_a", 1, 16'd0, 16'd9, 9, 0, 1, 0);
    run("zero_ab", 2, 16'd0, 16'd0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    a_in = {4{16'd4}};
    b_in = {4{16'd4}};
    #1;
    chk("rr_rst_outs", all_outs, 0);
    rst_n = 1'b1;
    #1;
    chk("rr_gnt0", gnt, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
        chk($sformatf("rr_gnt%0d", k), gnt, 64'(1) << (k % 4));
      end
      wait_resp(-1, lat, ld);
      chk($sformatf("rr_lat%0d", k), lat, 4);
      chk($sformatf("rr_id%0d", k), resp_id, k % 4);
      chk($sformatf("rr_busy_gnt%0d", k), gnt, 0);
      if (k == 4) req = '0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    a_in[15:0] = 16'd5;
    b_in[15:0] = 16'd1;
    a_in[31:16] = 16'd9;
    b_in[31:16] = 16'd6;
    req = 4'b0011;
    #1;
    chk("mid_gnt0", gnt, 4'b0001);
    @(negedge clk);
    req[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dp_ld_a && !dp_sel_in;
    end
    chk("mid_reach_suba", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", all_outs, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen || resp_valid;
    end
    chk("mid_no_resp", seen, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_gnt1", gnt, 4'b0010);
    wait_resp(1, lat, ld);
    chk("mid_lat", lat, 8);
    chk("mid_gcd", resp_gcd, 3);
    chk("mid_id", resp_id, 1);
    chk("mid_iters", resp_iters, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
